multicore_data_mem: RTL
=======================

# multicore_data_mem

Parametrised data-memory subsystem for the N-core ZueiraCore successor. It gives each of NCORES cores a private bank and one shared bank plus memory-mapped GPIN/GPOUT. Shared and I/O accesses go through a round-robin arbiter, and every access completes with a per-core ready handshake. It replaces the fixed two-core data memory and scales from 1 to 8 cores.

## Interface
- TAM, 16, data and address word width
- LMEM, 8, log2 words per bank (private bank per core and shared bank are both 2^LMEM words)
- NCORES, 4, number of cores, legal range 1..8
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- data_in  in  NCORES*TAM  write data, core i at [i*TAM +: TAM]
- data_addr  in  NCORES*TAM  word address per core, same packing
- data_load  in  NCORES  read request per core
- data_write  in  NCORES  write request per core
- data_out  out  NCORES*TAM  read data per core, registered
- data_ready  out  NCORES  one-cycle completion pulse per core
- GPIN  in  TAM  general-purpose input
- GPOUT  out  TAM  general-purpose output register

## Operation
- Address map, per core, with B = 2^LMEM:
  - 0..B-1 → own private bank.
  - B..2B-1 → shared bank, at word addr-B.
  - 0xFFFF (all ones) → GPIN, read-only.
  - 0xFFFE (all ones minus 1) → GPOUT, read/write.
  - Any other address is out-of-range: reads return 0, writes are ignored.
- Request = data_load | data_write. When both are high, the write wins, no read occurs, and data_out is unchanged.
- Per-core FSM:
  - IDLE: a request sampled at the edge goes to DONE for private or out-of-range addresses, and to WAIT for shared or I/O addresses.
  - WAIT: stays until granted. At the granting edge the access is performed and the core moves to DONE.
  - DONE: data_ready=1 and data_out holds the read result. The next edge returns to IDLE, and the request is ignored at that edge.
- Arbiter: one shared/I/O access per cycle. Candidates are cores in WAIT. Round-robin priority starts at (last granted + 1) mod NCORES; after reset the pointer is at core 0, so core 0 has highest priority. The pointer updates only on a grant.
- A request must stay stable from IDLE until data_ready. A core may change address/data in the DONE cycle.
- Private banks are independent, so all cores may access private memory in the same cycle.
- GPIN passes through a 2-flop synchroniser; reads return the synchronised value.
- GPOUT updates at the granting edge of a write to 0xFFFE.

## Timing
- Reset values: data_out=0, data_ready=0, GPOUT=0, all FSMs IDLE, RR pointer=0, GPIN synchroniser=0. Bank contents are not reset.
- Private or out-of-range access: request sampled at edge N, data_ready high and data_out valid in cycle N+1.
- Shared/I/O access, uncontended: edge N enters WAIT, grant at edge N+1, data_ready in cycle N+2.
- Contention: k cores in WAIT are serviced in k consecutive cycles, in RR order.
- Minimum spacing between accesses from one core is 2 cycles for private and 3 cycles for shared.
- Shared write followed by a read of the same word from another core returns the new value if that read is granted later.
- Reset asserted mid-operation: all WAIT/DONE states are dropped immediately, a pending write is not performed, and data_ready goes 0 asynchronously.
- NCORES=1: the arbiter degenerates to an always-grant, but shared latency stays unchanged.

## Test plan
- Private isolation: core0 writes 0x1234 to addr 0x05 and core1 writes 0xABCD to addr 0x05 in the same cycle. Read-back gives 0x1234 on core0 and 0xABCD on core1, with ready 1 cycle after each request.
- Shared contention: all 4 cores write to shared addr 0x100 (values 0x11..0x44) at the same edge just after reset. Grants go in order 0,1,2,3 on consecutive cycles, and the final read returns 0x44.
- RR fairness: core2 is granted, then cores 0 and 3 request simultaneously. Core3 is granted first, then core0.
- GPIO: write 0x00F0 to 0xFFFE → GPOUT=0x00F0 at the granting edge. Drive GPIN=0x5A5A, wait 2 cycles, read 0xFFFF → 0x5A5A.
- Boundaries: read from 0x0200 returns 0 with ready after 1 cycle. A write to 0x0200 leaves all banks unchanged. Load and write asserted together act as a write only.
- Reset mid-WAIT: core1 is waiting on a shared write and rst is pulsed low. After reset, data_ready=0, GPOUT=0, and a read of the target word shows the old value.

Source files
------------

// File: rtl/multicore_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : multicore_data_mem
// Brief    : N-core data memory. Each core has a private bank. All cores share
//            one bank and memory-mapped GPIN/GPOUT through a round-robin
//            arbiter. Every access ends with a one-cycle ready pulse.
// Revision : 1.0 - initial release
// ============================================================================
module multicore_data_mem #(
    parameter int TAM    = 16,
    parameter int LMEM   = 8,
    parameter int NCORES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCORES*TAM-1:0] data_in,
    input  logic [NCORES*TAM-1:0] data_addr,
    input  logic [NCORES-1:0]     data_load,
    input  logic [NCORES-1:0]     data_write,
    output logic [NCORES*TAM-1:0] data_out,
    output logic [NCORES-1:0]     data_ready,
    input  logic [TAM-1:0]        GPIN,
    output logic [TAM-1:0]        GPOUT
);

    localparam int                  BANK_WORDS  = 1 << LMEM;
    localparam int                  IDX_W       = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam logic [TAM-LMEM-1:0] PAGE_PRIV   = '0;
    localparam logic [TAM-LMEM-1:0] PAGE_SHARED = (TAM-LMEM)'(1);
    localparam logic [TAM-1:0]      ADDR_GPIN   = '1;
    localparam logic [TAM-1:0]      ADDR_GPOUT  = {{(TAM-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    logic [TAM-1:0]    shared_mem [BANK_WORDS];
    logic [TAM-1:0]    gpin_meta_q;
    logic [TAM-1:0]    gpin_sync_q;
    logic [TAM-1:0]    gpout_q;
    logic [IDX_W-1:0]  rr_q;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  cand;
    logic [NCORES-1:0] wait_vec;
    logic [NCORES-1:0] grant_vec;
    logic              grant_any;
    logic [TAM-1:0]    g_addr;
    logic [TAM-1:0]    g_wdata;
    logic              g_write;

    assign GPOUT = gpout_q;

    // Round-robin pick: the first waiting core found starting at the pointer.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int k = 0; k < NCORES; k++) begin
            cand = IDX_W'((int'(rr_q) + k) % NCORES);
            if (!grant_any && wait_vec[cand]) begin
                grant_any       = 1'b1;
                grant_idx       = cand;
                grant_vec[cand] = 1'b1;
            end
        end
    end

    assign g_addr  = data_addr[grant_idx*TAM +: TAM];
    assign g_wdata = data_in[grant_idx*TAM +: TAM];
    assign g_write = data_write[grant_idx];

    // Move the pointer to the core after the last granted one, only on a grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_q <= '0;
        end else if (grant_any) begin
            rr_q <= (int'(grant_idx) == NCORES - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    // Shared bank write port. It is driven only by the granted core.
    always_ff @(posedge clk) begin
        if (grant_any && g_write && (g_addr[TAM-1:LMEM] == PAGE_SHARED)) begin
            shared_mem[g_addr[LMEM-1:0]] <= g_wdata;
        end
    end

    // GPOUT register is written by a granted store to its address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpout_q <= '0;
        end else if (grant_any && g_write && (g_addr == ADDR_GPOUT)) begin
            gpout_q <= g_wdata;
        end
    end

    // Two-flop synchroniser for the asynchronous GPIN pins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gpin_meta_q <= '0;
            gpin_sync_q <= '0;
        end else begin
            gpin_meta_q <= GPIN;
            gpin_sync_q <= gpin_meta_q;
        end
    end

    for (genvar i = 0; i < NCORES; i++) begin : g_core
        logic [TAM-1:0] addr;
        logic [TAM-1:0] wdata;
        logic [TAM-1:0] dout_q;
        logic [TAM-1:0] priv_mem [BANK_WORDS];
        logic           is_priv;
        logic           is_shared;
        logic           is_gpin;
        logic           is_gpout;
        logic           is_io;
        logic           req;
        state_t         state_q;
        state_t         state_d;

        assign addr      = data_addr[i*TAM +: TAM];
        assign wdata     = data_in[i*TAM +: TAM];
        assign is_priv   = (addr[TAM-1:LMEM] == PAGE_PRIV);
        assign is_shared = (addr[TAM-1:LMEM] == PAGE_SHARED);
        assign is_gpin   = (addr == ADDR_GPIN);
        assign is_gpout  = (addr == ADDR_GPOUT);
        assign is_io     = is_shared | is_gpin | is_gpout;
        assign req       = data_load[i] | data_write[i];

        assign wait_vec[i]             = (state_q == S_WAIT);
        assign data_ready[i]           = (state_q == S_DONE);
        assign data_out[i*TAM +: TAM]  = dout_q;

        // State register. Reset drops any pending WAIT/DONE at once.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_q <= S_IDLE;
            end else begin
                state_q <= state_d;
            end
        end

        // Next state. Private and out-of-range accesses finish in one cycle.
        // Shared and I/O accesses wait for the arbiter.
        always_comb begin
            state_d = state_q;
            case (state_q)
                S_IDLE:  if (req) state_d = is_io ? S_WAIT : S_DONE;
                S_WAIT:  if (grant_vec[i]) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        // Private bank write. It is blocked while reset is held.
        always_ff @(posedge clk) begin
            if (rst && (state_q == S_IDLE) && data_write[i] && is_priv) begin
                priv_mem[addr[LMEM-1:0]] <= wdata;
            end
        end

        // Read data capture. A write, including load+write, leaves it unchanged.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else if (!data_write[i]) begin
                if ((state_q == S_IDLE) && data_load[i] && !is_io) begin
                    dout_q <= is_priv ? priv_mem[addr[LMEM-1:0]] : '0;
                end else if (grant_vec[i]) begin
                    dout_q <= is_shared ? shared_mem[addr[LMEM-1:0]] :
                              is_gpin   ? gpin_sync_q : gpout_q;
                end
            end
        end
    end

endmodule
`default_nettype wire
